fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 2-entry in-order {pc, instr} buffer.
//
// The unit issues single-cycle fetch requests to instruction memory. It keeps at
// most one request outstanding, and it issues a request only when the buffer has a
// free slot for the response. A taken branch flushes the buffer and redirects the
// fetch PC. A response that is still in flight during a redirect is dropped.
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   stall_i                 downstream holding; head entry is not consumed
//   branch_taken_i          redirect request; has priority over everything except reset
//   branch_target_i[31:0]   redirect address (bits [1:0] forced to 0)
//   imem_req_o              one-cycle fetch request (combinational)
//   imem_addr_o[31:0]       fetch address, meaningful while imem_req_o=1
//   imem_rvalid_i           in-order response strobe, >=1 cycle after its request
//   imem_rdata_i[31:0]      instruction word qualified by imem_rvalid_i
//   instr_o[31:0], PC_o     head entry (both 0 when valid_o=0)
//   valid_o                 buffer non-empty
//   fsm_state[1:0]          debug view of the request FSM (0 IDLE, 1 WAIT, 2 DISCARD)
//
// Handshake: the head entry is consumed on any cycle with valid_o=1, stall_i=0
// and branch_taken_i=0. The output side has no separate ready signal; stall_i=0
// acts as ready. The memory side has no back-pressure. A request is accepted in
// the cycle it is raised, and its response returns exactly once, in order.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] PC_o,
    output logic        valid_o,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [31:0]       req_pc;
    logic [1:0][31:0]  buf_pc;     // entry 0 is the head
    logic [1:0][31:0]  buf_instr;
    logic [1:0]        count;

    logic              push;
    logic              pop;
    logic              credit;
    logic [2:0]        occ;

    always_comb begin
        valid_o = (count != 2'd0);
        pop     = valid_o & ~stall_i & ~branch_taken_i;
        push    = (state == WAIT) & imem_rvalid_i & ~branch_taken_i;
        // The occupancy after this cycle must leave room for the response of any
        // request issued now. pop implies count>=1, so this cannot underflow.
        occ     = {1'b0, count} + {2'b00, push} - {2'b00, pop};
        credit  = (occ < 3'd2);
        // In WAIT, a new request may overlap the response that retires the old one.
        imem_req_o  = ~rst_i & ~branch_taken_i & credit &
                      ((state == IDLE) | ((state == WAIT) & imem_rvalid_i));
        imem_addr_o = fetch_pc;
        instr_o     = valid_o ? buf_instr[0] : 32'h0;
        PC_o        = valid_o ? buf_pc[0]    : 32'h0;
        fsm_state   = state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            count     <= 2'd0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else if (branch_taken_i) begin
            count    <= 2'd0;
            fetch_pc <= branch_target_i & 32'hFFFF_FFFC;
            // A response arriving right now is the one outstanding, so it is
            // dropped here and nothing remains in flight. Otherwise the pending
            // response must still be swallowed when it arrives.
            case (state)
                WAIT:    state <= imem_rvalid_i ? IDLE : DISCARD;
                DISCARD: state <= imem_rvalid_i ? IDLE : DISCARD;
                default: state <= IDLE;
            endcase
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf_pc[0]    <= req_pc;
                        buf_instr[0] <= imem_rdata_i;
                    end else begin
                        buf_pc[1]    <= req_pc;
                        buf_instr[1] <= imem_rdata_i;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf_pc[0]    <= buf_pc[1];
                    buf_instr[0] <= buf_instr[1];
                    count        <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: the new entry lands behind the
                    // survivor, or becomes the head if the buffer held one entry.
                    if (count == 2'd1) begin
                        buf_pc[0]    <= req_pc;
                        buf_instr[0] <= imem_rdata_i;
                    end else begin
                        buf_pc[0]    <= buf_pc[1];
                        buf_instr[0] <= buf_instr[1];
                        buf_pc[1]    <= req_pc;
                        buf_instr[1] <= imem_rdata_i;
                    end
                end
                default: ;
            endcase

            if (imem_req_o) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
                state    <= WAIT;
            end else if ((state != IDLE) && imem_rvalid_i) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a behavioural instruction memory with variable
// latency, a program-order reference stream held in exp_q, a monitor that pops
// and compares on every consumed head entry, directed scenarios, then a random
// phase.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] PC_o;
    logic        valid_o;
    logic [1:0]  fsm_state;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .PC_o            (PC_o),
        .valid_o         (valid_o),
        .fsm_state       (fsm_state)
    );

    // ---------------- checking infrastructure ----------------
    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT event at %0t", name, $time);
    endtask

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model: program-order stream ----------------
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = pc & 32'hFFFF_FFFC;
    endtask

    task automatic model_fill();
        while (exp_q.size() < 4) begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endtask

    // ---------------- instruction memory model ----------------
    int          lat_min = 1;
    int          lat_max = 1;
    logic        mem_out = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    initial begin
        logic        s_req, s_rst, s_rv;
        logic [31:0] s_addr;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk);
            s_req  = imem_req_o;
            s_addr = imem_addr_o;
            s_rst  = rst_i;
            s_rv   = imem_rvalid_i;
            #1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom();
            if (s_rst) begin
                mem_out = 1'b0;
            end else begin
                if (s_rv) mem_out = 1'b0;
                if (s_req) begin
                    check32("single_outstanding", {31'b0, mem_out}, 32'h0);
                    check32("addr_aligned", {30'b0, s_addr[1:0]}, 32'h0);
                    mem_out  = 1'b1;
                    mem_addr = s_addr;
                    mem_cnt  = $urandom_range(lat_max, lat_min);
                end
                if (mem_out) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i  = mem_word(mem_addr);
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    int          idle = 0;
    logic [63:0] e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_hold = 1'b0;
                idle      = 0;
            end else begin
                check32("state_legal", {31'b0, fsm_state == 2'd3}, 32'h0);
                if (prev_hold) begin
                    check32("stall_valid", {31'b0, valid_o}, 32'h1);
                    check32("stall_pc", PC_o, prev_pc);
                    check32("stall_instr", instr_o, prev_instr);
                end
                if (!valid_o) begin
                    check32("idle_pc_zero", PC_o, 32'h0);
                    check32("idle_instr_zero", instr_o, 32'h0);
                end
                if (valid_o && !stall_i && !branch_taken_i) begin
                    model_fill();
                    e = exp_q.pop_front();
                    check32("stream_pc", PC_o, e[63:32]);
                    check32("stream_instr", instr_o, e[31:0]);
                    idle = 0;
                end else if (branch_taken_i) begin
                    idle = 0;
                end else if (!stall_i) begin
                    idle++;
                    if (idle > 16) begin
                        timeout_fail("progress");
                        idle = 0;
                    end
                end
                prev_hold  = valid_o && stall_i && !branch_taken_i;
                prev_pc    = PC_o;
                prev_instr = instr_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_i          = 1'b1;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        model_restart(RESET_PC);
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] t);
        branch_taken_i  = 1'b1;
        branch_target_i = t;
        model_restart(t);
        step();
        branch_taken_i  = 1'b0;
        branch_target_i = $urandom();
    endtask

    task automatic wait_mem(input bit want_out_no_rv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (want_out_no_rv ? (mem_out && !imem_rvalid_i) : imem_rvalid_i) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          ok;
        bit          seen_req;
        int          n;
        logic [31:0] got [3];
        logic [31:0] tgt;
        int          r;

        // Reset release with 1-cycle memory: request in cycle 0, valid from cycle 2.
        lat_min = 1; lat_max = 1;
        do_reset(2);
        @(negedge clk);
        check32("first_req", {31'b0, imem_req_o}, 32'h1);
        check32("first_addr", imem_addr_o, RESET_PC);
        check32("c0_valid", {31'b0, valid_o}, 32'h0);
        step(); @(negedge clk);
        check32("c1_valid", {31'b0, valid_o}, 32'h0);
        step(); @(negedge clk);
        check32("c2_valid", {31'b0, valid_o}, 32'h1);
        check32("c2_pc", PC_o, RESET_PC);
        step(); @(negedge clk);
        check32("c3_pc", PC_o, RESET_PC + 32'd4);
        step(); @(negedge clk);
        check32("c4_pc", PC_o, RESET_PC + 32'd8);
        repeat (5) step();

        // Five-cycle stall: buffer fills, requests stop, head held.
        stall_i = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check32("stall_req_stops", {31'b0, imem_req_o}, 32'h0);
        check32("stall_full_valid", {31'b0, valid_o}, 32'h1);
        step();
        stall_i = 1'b0;
        repeat (10) step();

        // Redirect with a request outstanding on 3-cycle memory.
        lat_min = 3; lat_max = 3;
        repeat (10) step();
        wait_mem(1'b1, ok);
        if (!ok) timeout_fail("wait_outstanding");
        do_branch(32'h0000_0103);
        ok = 1'b0; seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_o && !seen_req) begin
                seen_req = 1'b1;
                check32("redir_first_req", imem_addr_o, 32'h0000_0100);
            end
            if (valid_o) begin
                check32("redir_first_pc", PC_o, 32'h0000_0100);
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout_fail("redir_valid");
        repeat (8) step();

        // Redirect in the same cycle as a response.
        lat_min = 2; lat_max = 2;
        repeat (6) step();
        wait_mem(1'b0, ok);
        if (!ok) timeout_fail("wait_rvalid");
        do_branch(32'h0000_2000);
        @(negedge clk);
        check32("same_cycle_req", {31'b0, imem_req_o}, 32'h1);
        check32("same_cycle_addr", imem_addr_o, 32'h0000_2000);
        check32("same_cycle_valid", {31'b0, valid_o}, 32'h0);
        repeat (8) step();

        // Fetch address wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        do_branch(32'hFFFF_FFF9);
        n = 0;
        for (int i = 0; i < 12 && n < 3; i++) begin
            @(negedge clk);
            if (imem_req_o) begin
                got[n] = imem_addr_o;
                n++;
            end
            step();
        end
        if (n < 3) timeout_fail("wrap_reqs");
        else begin
            check32("wrap_a0", got[0], 32'hFFFF_FFF8);
            check32("wrap_a1", got[1], 32'hFFFF_FFFC);
            check32("wrap_a2", got[2], 32'h0000_0000);
        end
        repeat (6) step();

        // Reset while buffered and with a request outstanding.
        lat_min = 3; lat_max = 3;
        stall_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_out && valid_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout_fail("wait_busy");
        rst_i = 1'b1;
        model_restart(RESET_PC);
        @(negedge clk);
        check32("rst_cycle_req", {31'b0, imem_req_o}, 32'h0);
        step();
        rst_i   = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        check32("post_rst_valid", {31'b0, valid_o}, 32'h0);
        check32("post_rst_pc", PC_o, 32'h0);
        check32("post_rst_instr", instr_o, 32'h0);
        check32("post_rst_req", {31'b0, imem_req_o}, 32'h1);
        check32("post_rst_addr", imem_addr_o, RESET_PC);
        repeat (10) step();

        // Random phase: stalls, redirects, occasional resets, varying latency.
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 0) begin
                lat_min = 1;
                lat_max = 1 + (c / 300) % 3;
            end
            r = $urandom_range(99, 0);
            stall_i = ($urandom_range(99, 0) < 30);
            if (r < 5) begin
                case ($urandom_range(3, 0))
                    0:       tgt = 32'hFFFF_FFE0 | ($urandom() & 32'h1F);
                    1:       tgt = $urandom() & 32'h0000_0FFF;
                    default: tgt = $urandom();
                endcase
                do_branch(tgt);
            end else if (r == 5) begin
                do_reset(1);
            end else begin
                step();
            end
        end
        stall_i = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
